alu_ctrl_encoder: RTL and testbench

- ID/EX-stage encoder that produces the 4-bit ALU operation code and operand-steering controls consumed by the EX-stage ALU.
- Decodes MIPS opcode and funct fields into the ALU op encoding and registers the result into the ID/EX boundary.
- Supports stall (hold) and flush (bubble).
- Keeps a saturating count of illegal ALU-class instructions for debug.

---
 rtl/alu_ctrl_encoder_if.sv | 39 +++
 rtl/alu_ctrl_encoder.sv | 148 ++++++++++++++
 tb/tb_alu_ctrl_encoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_encoder_if.sv
// Bus between the ID-stage instruction fields and the registered EX-stage
// ALU controls produced by alu_ctrl_encoder.
interface alu_ctrl_encoder_if #(
  parameter int CNT_WIDTH = 8
);

  // ID-stage side
  logic                 i_valid;
  logic [5:0]           i_opcode;
  logic [5:0]           i_funct;
  logic                 i_stall;
  logic                 i_flush;
  logic                 i_cnt_clr;

  // EX-stage side
  logic                 o_valid;
  logic [3:0]           o_alu_ctrl;
  logic                 o_alu_src_imm;
  logic                 o_imm_zext;
  logic                 o_shift;
  logic                 o_shamt_var;
  logic                 o_illegal;
  logic [CNT_WIDTH-1:0] o_illegal_cnt;

  // Pipeline control logic that feeds instructions and consumes the controls
  modport master (
    output i_valid, i_opcode, i_funct, i_stall, i_flush, i_cnt_clr,
    input  o_valid, o_alu_ctrl, o_alu_src_imm, o_imm_zext, o_shift,
           o_shamt_var, o_illegal, o_illegal_cnt
  );

  // The encoder itself
  modport slave (
    input  i_valid, i_opcode, i_funct, i_stall, i_flush, i_cnt_clr,
    output o_valid, o_alu_ctrl, o_alu_src_imm, o_imm_zext, o_shift,
           o_shamt_var, o_illegal, o_illegal_cnt
  );

endinterface

// File: rtl/alu_ctrl_encoder.sv
// ID/EX-stage ALU control encoder: decodes MIPS opcode/funct into a 4-bit ALU
// op plus operand-steering flags, registers them across the ID/EX boundary
// with stall/flush support, and keeps a saturating count of illegal
// instructions for debug.
module alu_ctrl_encoder #(
  parameter int CNT_WIDTH = 8
) (
  input logic            i_clk,
  input logic            i_rst_n,
  alu_ctrl_encoder_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } aluOp_e;

  aluOp_e               aluCtrl_d;
  logic                 valid_d;
  logic                 srcImm_d;
  logic                 immZext_d;
  logic                 shift_d;
  logic                 shamtVar_d;
  logic                 illegal_d;

  aluOp_e               aluCtrl_q;
  logic                 valid_q;
  logic                 srcImm_q;
  logic                 immZext_q;
  logic                 shift_q;
  logic                 shamtVar_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] illegalCnt_q;

  logic                 capture;
  logic                 cntSat;

  // A capture edge is one that is neither flushed nor stalled
  assign capture = !bus.i_flush && !bus.i_stall;
  assign cntSat  = (illegalCnt_q == {CNT_WIDTH{1'b1}});

  // Combinational decode; an invalid slot decodes to a bubble so the fields are ignored
  always_comb begin
    aluCtrl_d  = OP_ADD;
    valid_d    = bus.i_valid;
    srcImm_d   = 1'b0;
    immZext_d  = 1'b0;
    shift_d    = 1'b0;
    shamtVar_d = 1'b0;
    illegal_d  = 1'b0;

    unique case (bus.i_opcode)
      6'b000000: begin
        unique case (bus.i_funct)
          6'b100000, 6'b100001: aluCtrl_d = OP_ADD;
          6'b100010, 6'b100011: aluCtrl_d = OP_SUB;
          6'b100100:            aluCtrl_d = OP_AND;
          6'b100101:            aluCtrl_d = OP_OR;
          6'b100110:            aluCtrl_d = OP_XOR;
          6'b101010:            aluCtrl_d = OP_SLT;
          6'b101011:            aluCtrl_d = OP_SLTU;
          6'b000000: begin aluCtrl_d = OP_SLL; shift_d = 1'b1; end
          6'b000010: begin aluCtrl_d = OP_SRL; shift_d = 1'b1; end
          6'b000011: begin aluCtrl_d = OP_SRA; shift_d = 1'b1; end
          6'b000100: begin aluCtrl_d = OP_SLL; shift_d = 1'b1; shamtVar_d = 1'b1; end
          6'b000110: begin aluCtrl_d = OP_SRL; shift_d = 1'b1; shamtVar_d = 1'b1; end
          6'b000111: begin aluCtrl_d = OP_SRA; shift_d = 1'b1; shamtVar_d = 1'b1; end
          default:              illegal_d = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin aluCtrl_d = OP_ADD;  srcImm_d = 1'b1; end
      6'b001010:            begin aluCtrl_d = OP_SLT;  srcImm_d = 1'b1; end
      6'b001011:            begin aluCtrl_d = OP_SLTU; srcImm_d = 1'b1; end
      6'b001100: begin aluCtrl_d = OP_AND; srcImm_d = 1'b1; immZext_d = 1'b1; end
      6'b001101: begin aluCtrl_d = OP_OR;  srcImm_d = 1'b1; immZext_d = 1'b1; end
      6'b001110: begin aluCtrl_d = OP_XOR; srcImm_d = 1'b1; immZext_d = 1'b1; end
      6'b100011, 6'b101011: begin aluCtrl_d = OP_ADD; srcImm_d = 1'b1; end
      6'b000100, 6'b000101: aluCtrl_d = OP_SUB;
      default:              illegal_d = 1'b1;
    endcase

    // Illegal instructions fall back to a plain ADD with no steering
    if (illegal_d) begin
      aluCtrl_d  = OP_ADD;
      srcImm_d   = 1'b0;
      immZext_d  = 1'b0;
      shift_d    = 1'b0;
      shamtVar_d = 1'b0;
    end

    if (!bus.i_valid) begin
      aluCtrl_d  = OP_ADD;
      srcImm_d   = 1'b0;
      immZext_d  = 1'b0;
      shift_d    = 1'b0;
      shamtVar_d = 1'b0;
      illegal_d  = 1'b0;
    end
  end

  // ID/EX control register: reset, then flush to a bubble, then hold on stall, else capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_flush) begin
      valid_q    <= 1'b0;
      aluCtrl_q  <= OP_ADD;
      srcImm_q   <= 1'b0;
      immZext_q  <= 1'b0;
      shift_q    <= 1'b0;
      shamtVar_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (!bus.i_stall) begin
      valid_q    <= valid_d;
      aluCtrl_q  <= aluCtrl_d;
      srcImm_q   <= srcImm_d;
      immZext_q  <= immZext_d;
      shift_q    <= shift_d;
      shamtVar_q <= shamtVar_d;
      illegal_q  <= illegal_d;
    end
  end

  // Saturating illegal-instruction counter; clear beats a same-edge increment
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_cnt_clr) begin
      illegalCnt_q <= '0;
    end else if (capture && illegal_d && !cntSat) begin
      illegalCnt_q <= illegalCnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_alu_ctrl    = aluCtrl_q;
  assign bus.o_alu_src_imm = srcImm_q;
  assign bus.o_imm_zext    = immZext_q;
  assign bus.o_shift       = shift_q;
  assign bus.o_shamt_var   = shamtVar_q;
  assign bus.o_illegal     = illegal_q;
  assign bus.o_illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Directed testbench for alu_ctrl_encoder. Two instances share the same
// stimulus: one with an 8-bit illegal counter and one with a 2-bit counter
// so saturation is reachable in a few cycles.
module tb_alu_ctrl_encoder;

  logic clk;
  logic rstN;
  int   compared;
  int   mismatched;

  alu_ctrl_encoder_if #(.CNT_WIDTH(8)) ifA ();
  alu_ctrl_encoder_if #(.CNT_WIDTH(2)) ifB ();

  alu_ctrl_encoder #(.CNT_WIDTH(8)) dutA (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (ifA)
  );

  alu_ctrl_encoder #(.CNT_WIDTH(2)) dutB (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (ifB)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the same instruction fields into both instances
  task automatic applyStimulus(input logic valid, input logic [5:0] opcode,
                               input logic [5:0] funct, input logic stall,
                               input logic flush, input logic clr);
    ifA.i_valid = valid;  ifB.i_valid = valid;
    ifA.i_opcode = opcode; ifB.i_opcode = opcode;
    ifA.i_funct = funct;  ifB.i_funct = funct;
    ifA.i_stall = stall;  ifB.i_stall = stall;
    ifA.i_flush = flush;  ifB.i_flush = flush;
    ifA.i_cnt_clr = clr;  ifB.i_cnt_clr = clr;
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {valid, ctrl, srcImm, zext, shift, shamtVar, illegal} on both instances
  task automatic checkOutput(input string tag, input logic expValid,
                             input logic [3:0] expCtrl, input logic [4:0] expFlags);
    logic [9:0] expVec;
    logic [9:0] obsA;
    logic [9:0] obsB;
    expVec = {expValid, expCtrl, expFlags};
    obsA = {ifA.o_valid, ifA.o_alu_ctrl, ifA.o_alu_src_imm, ifA.o_imm_zext,
            ifA.o_shift, ifA.o_shamt_var, ifA.o_illegal};
    obsB = {ifB.o_valid, ifB.o_alu_ctrl, ifB.o_alu_src_imm, ifB.o_imm_zext,
            ifB.o_shift, ifB.o_shamt_var, ifB.o_illegal};
    compared++;
    assert (obsA === expVec) else begin
      mismatched++;
      $error("[TB] FAIL %s/A observed=%b expected=%b", tag, obsA, expVec);
    end
    compared++;
    assert (obsB === expVec) else begin
      mismatched++;
      $error("[TB] FAIL %s/B observed=%b expected=%b", tag, obsB, expVec);
    end
  endtask

  // Compare the illegal counters of both instances
  task automatic checkCount(input string tag, input logic [7:0] expA,
                            input logic [1:0] expB);
    compared++;
    assert (ifA.o_illegal_cnt === expA) else begin
      mismatched++;
      $error("[TB] FAIL %s/cntA observed=%0d expected=%0d", tag, ifA.o_illegal_cnt, expA);
    end
    compared++;
    assert (ifB.o_illegal_cnt === expB) else begin
      mismatched++;
      $error("[TB] FAIL %s/cntB observed=%0d expected=%0d", tag, ifB.o_illegal_cnt, expB);
    end
  endtask

  // Directed sequence; flags are {srcImm, zext, shift, shamtVar, illegal}
  initial begin
    logic [7:0] expA;
    logic [1:0] expB;
    compared   = 0;
    mismatched = 0;

    // Reset with random fields for two edges
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'($urandom_range(1)), 6'($urandom_range(63)), 6'($urandom_range(63)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      tick();
    end
    checkOutput("reset", 1'b0, 4'b0000, 5'b00000);
    checkCount("reset", 8'd0, 2'd0);
    rstN = 1'b1;

    // R-type
    applyStimulus(1'b1, 6'b000000, 6'b100010, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_sub", 1'b1, 4'b0001, 5'b00000);
    applyStimulus(1'b1, 6'b000000, 6'b000111, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_srav", 1'b1, 4'b0111, 5'b00110);
    applyStimulus(1'b1, 6'b000000, 6'b101011, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_sltu", 1'b1, 4'b1001, 5'b00000);
    applyStimulus(1'b1, 6'b000000, 6'b000010, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_srl", 1'b1, 4'b0110, 5'b00100);
    applyStimulus(1'b1, 6'b000000, 6'b100101, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_or", 1'b1, 4'b0011, 5'b00000);

    // I-type and branches
    applyStimulus(1'b1, 6'b001101, 6'b101010, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("i_ori", 1'b1, 4'b0011, 5'b11000);
    applyStimulus(1'b1, 6'b001010, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("i_slti", 1'b1, 4'b1000, 5'b10000);
    applyStimulus(1'b1, 6'b100011, 6'b000111, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("i_lw", 1'b1, 4'b0000, 5'b10000);
    applyStimulus(1'b1, 6'b000100, 6'b100100, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("i_beq", 1'b1, 4'b0001, 5'b00000);
    applyStimulus(1'b1, 6'b101011, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("i_sw", 1'b1, 4'b0000, 5'b10000);
    checkCount("legal_ops", 8'd0, 2'd0);

    // Illegal R-type funct
    applyStimulus(1'b1, 6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_illegal", 1'b1, 4'b0000, 5'b00001);
    checkCount("r_illegal", 8'd1, 2'd1);

    // Capture xori, then stall three edges while fields change (including an illegal one)
    applyStimulus(1'b1, 6'b001110, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("xori", 1'b1, 4'b0100, 5'b11000);
    applyStimulus(1'b1, 6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0); tick();
    checkOutput("stall1", 1'b1, 4'b0100, 5'b11000);
    applyStimulus(1'b0, 6'b001010, 6'b000000, 1'b1, 1'b0, 1'b0); tick();
    checkOutput("stall2", 1'b1, 4'b0100, 5'b11000);
    applyStimulus(1'b1, 6'b111111, 6'b000000, 1'b1, 1'b0, 1'b0); tick();
    checkOutput("stall3", 1'b1, 4'b0100, 5'b11000);
    checkCount("stall_illegal", 8'd1, 2'd1);

    // Stall and flush together: flush wins
    applyStimulus(1'b1, 6'b001101, 6'b000000, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("stall_flush", 1'b0, 4'b0000, 5'b00000);

    // Three illegal captures
    expA = 8'd1;
    expB = 2'd1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
      expA = expA + 8'd1;
      if (expB != 2'd3) expB = expB + 2'd1;
      checkOutput("illegal_op", 1'b1, 4'b0000, 5'b00001);
      checkCount("illegal_op", expA, expB);
    end

    // Illegal opcode with valid low is a bubble and is not counted
    applyStimulus(1'b0, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("illegal_novalid", 1'b0, 4'b0000, 5'b00000);
    checkCount("illegal_novalid", 8'd4, 2'd3);

    // Flushed illegal is not counted
    applyStimulus(1'b1, 6'b111111, 6'b000000, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("illegal_flush", 1'b0, 4'b0000, 5'b00000);
    checkCount("illegal_flush", 8'd4, 2'd3);

    // Clear beats a simultaneous illegal capture
    applyStimulus(1'b1, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("clr_capture", 1'b1, 4'b0000, 5'b00001);
    checkCount("clr_capture", 8'd0, 2'd0);

    // Five illegal captures saturate the narrow counter
    expA = 8'd0;
    expB = 2'd0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 6'b010000, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
      expA = expA + 8'd1;
      if (expB != 2'd3) expB = expB + 2'd1;
      checkCount("saturate", expA, expB);
    end
    checkOutput("saturate", 1'b1, 4'b0000, 5'b00001);

    // Clear during a stall zeroes the count while outputs hold
    applyStimulus(1'b1, 6'b001101, 6'b000000, 1'b1, 1'b0, 1'b1); tick();
    checkOutput("clr_stall", 1'b1, 4'b0000, 5'b00001);
    checkCount("clr_stall", 8'd0, 2'd0);

    // Build a nonzero count, then reset during stall+flush
    applyStimulus(1'b1, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0); tick();
    checkCount("pre_reset", 8'd1, 2'd1);
    rstN = 1'b0;
    applyStimulus(1'b1, 6'b001101, 6'b000000, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("reset_mid", 1'b0, 4'b0000, 5'b00000);
    checkCount("reset_mid", 8'd0, 2'd0);
    rstN = 1'b1;

    // Valid ADD after reset is distinguishable from a bubble by o_valid
    applyStimulus(1'b1, 6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_addu", 1'b1, 4'b0000, 5'b00000);
    applyStimulus(1'b1, 6'b000000, 6'b000100, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("r_sllv", 1'b1, 4'b0101, 5'b00110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
